// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned NUM_M        = 2;
    localparam logic [31:0] ERR_DATA_DEF = 32'hffff_ffff;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } mem_req_t;

endpackage

// File: rtl/mem_req_latch.sv
// Per-master request capture: turns a rising rd/we level into a pending
// request and flags a new request that arrives while one is still pending.
module mem_req_latch
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        clr,
    output logic        pending,
    output mem_req_t    req,
    output logic        viol
);

    logic lvl_q;
    logic fire;

    assign fire = (rd | we) & ~lvl_q;
    // The completing cycle frees the slot, so a request then is accepted.
    assign viol = fire & pending & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q   <= 1'b0;
            pending <= 1'b0;
            req     <= '0;
        end else begin
            lvl_q <= rd | we;
            if (fire && (!pending || clr)) begin
                pending <= 1'b1;
                req     <= '{a: a, d: d, we: we};
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single system memory port: one slave
// transaction at a time, with timeout and a one-cycle ready per completion.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit          RR_EN    = 1'b1,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_rd,
    input  logic        m0_we,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_rd,
    input  logic        m1_we,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_rd,
    output logic        s_we,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        bus_err
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    arb_state_t                   state;
    logic                         own;
    logic                         prio;
    logic                         pick;
    logic [7:0]                   timer;
    logic [NUM_M-1:0]             m_rd, m_we, pend, viol, clr, ready;
    logic [NUM_M-1:0][31:0]       m_a, m_d, spo;
    mem_req_t                     req [NUM_M];

    assign m_rd = {m1_rd, m0_rd};
    assign m_we = {m1_we, m0_we};
    assign m_a  = {m1_a, m0_a};
    assign m_d  = {m1_d, m0_d};

    for (genvar i = 0; i < NUM_M; i++) begin : g_lat
        assign clr[i] = (state == ST_DONE) && (own == 1'(i));
        mem_req_latch u_lat (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd      (m_rd[i]),
            .we      (m_we[i]),
            .a       (m_a[i]),
            .d       (m_d[i]),
            .clr     (clr[i]),
            .pending (pend[i]),
            .req     (req[i]),
            .viol    (viol[i])
        );
    end

    // prio names the master preferred on a tie; it moves away from each owner.
    always_comb begin
        pick = pend[1] & ~pend[0];
        if (&pend) pick = RR_EN ? prio : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            own     <= 1'b0;
            prio    <= 1'b0;
            timer   <= '0;
            grant   <= '0;
            s_a     <= '0;
            s_d     <= '0;
            s_rd    <= 1'b0;
            s_we    <= 1'b0;
            ready   <= '0;
            spo     <= '0;
            bus_err <= 1'b0;
        end else begin
            s_rd    <= 1'b0;
            s_we    <= 1'b0;
            ready   <= '0;
            spo     <= '0;
            bus_err <= |viol;
            unique case (state)
                ST_IDLE: if (|pend) begin
                    own   <= pick;
                    grant <= pick ? 2'b10 : 2'b01;
                    s_a   <= req[pick].a;
                    s_d   <= req[pick].d;
                    s_rd  <= ~req[pick].we;
                    s_we  <= req[pick].we;
                    timer <= 8'd1;
                    state <= ST_ISSUE;
                end
                ST_ISSUE, ST_WAIT: begin
                    // timer holds the count of ISSUE/WAIT cycles including this one
                    if (s_ready || timer >= TO) begin
                        ready[own] <= 1'b1;
                        spo[own]   <= s_ready ? s_spo : ERR_DATA;
                        bus_err    <= (|viol) | ~s_ready;
                        s_a        <= '0;
                        s_d        <= '0;
                        state      <= ST_DONE;
                    end else begin
                        timer <= timer + 8'd1;
                        state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    grant <= '0;
                    prio  <= ~own;
                    timer <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m0_ready = ready[0];
    assign m1_ready = ready[1];
    assign m0_spo   = spo[0];
    assign m1_spo   = spo[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a scoreboard of expected completions
// and a behavioural slave whose response latency is set per step.
module tb_mem_bus_arbiter;

    localparam logic [31:0] ERR = 32'hffff_ffff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m0_a = '0, m0_d = '0, m1_a = '0, m1_d = '0;
    logic        m0_rd = 1'b0, m0_we = 1'b0, m1_rd = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_spo, m1_spo, s_a, s_d;
    logic        m0_ready, m1_ready, s_rd, s_we, bus_err;
    logic [31:0] s_spo = '0;
    logic        s_ready = 1'b0;
    logic [1:0]  grant;

    mem_bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(4), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_a(m0_a), .m0_d(m0_d), .m0_rd(m0_rd), .m0_we(m0_we),
        .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_rd(m1_rd), .m1_we(m1_we),
        .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_a(s_a), .s_d(s_d), .s_rd(s_rd), .s_we(s_we),
        .s_spo(s_spo), .s_ready(s_ready),
        .grant(grant), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit m; logic [31:0] spo; bit err; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'he300_0000;
    endfunction

    // Slave: answers slave_lat cycles after the strobe (0 = in ISSUE, <0 = never).
    int          slave_lat = 0, cnt = -1, n_strobe = 0;
    logic [31:0] last_a = '0, last_d = '0;
    logic        last_we = 1'b0;
    always @(negedge clk) begin
        s_ready = 1'b0;
        s_spo   = '0;
        if (!rst_n) begin
            cnt = -1;
        end else if (s_rd || s_we) begin
            n_strobe++;
            last_a = s_a; last_d = s_d; last_we = s_we;
            cnt = slave_lat;
        end else if (cnt > 0) begin
            cnt--;
        end
        if (rst_n && cnt == 0) begin
            s_ready = 1'b1;
            s_spo   = last_we ? 32'h0 : slave_data(last_a);
            cnt     = -1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input bit m, input bit we, input logic [31:0] a, input bit err);
        exp_t e;
        e.m = m; e.err = err;
        e.spo = err ? ERR : (we ? 32'h0 : slave_data(a));
        sb.push_back(e);
    endtask

    task automatic drive(input bit m, input bit rd, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        if (m) begin m1_rd = rd; m1_we = we; m1_a = a; m1_d = d; end
        else   begin m0_rd = rd; m0_we = we; m0_a = a; m0_d = d; end
    endtask

    task automatic release_m(input bit m);
        if (m) begin m1_rd = 1'b0; m1_we = 1'b0; end
        else   begin m0_rd = 1'b0; m0_we = 1'b0; end
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL %s: ready %b%b with no expected completion", tag, m1_ready, m0_ready);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_ready"}, 32'({m1_ready, m0_ready}), e.m ? 32'd2 : 32'd1);
        chk({tag, "_spo"}, e.m ? m1_spo : m0_spo, e.spo);
        chk({tag, "_other_spo"}, e.m ? m0_spo : m1_spo, 32'h0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'(e.err));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(m0_ready || m1_ready) && n < 200);
        if (!(m0_ready || m1_ready)) begin
            n_chk++;
            $error("FAIL %s: no ready within %0d cycles", tag, n);
        end else begin
            check_done(tag);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        release_m(1'b0); release_m(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({grant, s_rd, s_we, m0_ready, m1_ready, bus_err}), 32'h0);
        chk("rst_data", s_a | s_d | m0_spo | m1_spo, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0;
        bit who, seen;
        logic [31:0] addr;

        do_reset();

        // T1: single read, slave answers in ISSUE, ready three cycles after request
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'hf000_0000, 32'h0);
        push(1'b0, 1'b0, 32'hf000_0000, 1'b0);
        @(posedge clk); #1; release_m(1'b0);
        @(negedge clk); chk("t1_idle_grant", 32'(grant), 32'h0);
        @(negedge clk);
        chk("t1_issue_strb", 32'({s_rd, s_we}), 32'h2);
        chk("t1_issue_a", s_a, 32'hf000_0000);
        chk("t1_issue_grant", 32'(grant), 32'h1);
        @(negedge clk); check_done("t1");
        chk("t1_spo_val", m0_spo, 32'h1300_0000);

        // T2: simultaneous read and write, m0 first from reset
        do_reset();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hdead_beef);
        push(1'b0, 1'b0, 32'h200, 1'b0);
        push(1'b1, 1'b1, 32'h100, 1'b0);
        @(posedge clk); #1; release_m(1'b0); release_m(1'b1);
        wait_done("t2_m0");
        wait_done("t2_m1");
        chk("t2_s_we", 32'(last_we), 32'h1);
        chk("t2_s_a", last_a, 32'h100);
        chk("t2_s_d", last_d, 32'hdead_beef);

        // T3: back-to-back re-requests in the ready cycle must alternate owners
        slave_lat = 1;
        addr = 32'h1000;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, addr, 32'h0); push(1'b0, 1'b0, addr, 1'b0);
        addr += 4;
        drive(1'b1, 1'b1, 1'b0, addr, 32'h0); push(1'b1, 1'b0, addr, 1'b0);
        addr += 4;
        @(posedge clk); #1; release_m(1'b0); release_m(1'b1);
        for (int i = 0; i < 8; i++) begin
            wait_done("t3");
            if (i < 6) begin
                who = m1_ready;
                drive(who, 1'b1, 1'b0, addr, 32'h0); push(who, 1'b0, addr, 1'b0);
                addr += 4;
                @(posedge clk); #1; release_m(who);
            end
        end

        // T4: slave never answers, forced error after four ISSUE/WAIT cycles
        slave_lat = -1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h0); push(1'b0, 1'b0, 32'h300, 1'b1);
        t0 = cyc;
        @(posedge clk); #1; release_m(1'b0);
        wait_done("t4");
        chk("t4_latency", 32'(cyc - t0), 32'd6);

        // T5: second pulse while pending flags bus_err and is dropped
        slave_lat = 3;
        s0 = n_strobe;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h55); push(1'b1, 1'b1, 32'h400, 1'b0);
        @(posedge clk); #1; release_m(1'b1);
        @(posedge clk); #1; drive(1'b1, 1'b1, 1'b0, 32'h444, 32'h0);
        @(posedge clk); #1; release_m(1'b1);
        @(negedge clk); chk("t5_err_pulse", 32'(bus_err), 32'h1);
        @(negedge clk); chk("t5_err_clear", 32'(bus_err), 32'h0);
        wait_done("t5");
        repeat (4) @(negedge clk);
        chk("t5_one_txn", 32'(n_strobe - s0), 32'd1);
        chk("t5_last_a", last_a, 32'h400);

        // T6: reset in WAIT drops the transaction; the next one is clean
        slave_lat = -1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h600, 32'h0); push(1'b0, 1'b0, 32'h600, 1'b1);
        @(posedge clk); #1; release_m(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_wait_grant", 32'({grant, s_rd, s_we}), 32'h4);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_rst_ctrl", 32'({grant, s_rd, s_we, m0_ready, m1_ready, bus_err}), 32'h0);
        chk("t6_rst_a", s_a, 32'h0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        s0 = n_strobe;
        seen = 1'b0;
        repeat (8) begin @(negedge clk); seen |= m0_ready | m1_ready; end
        chk("t6_no_ready", 32'(seen), 32'h0);
        chk("t6_no_strobe", 32'(n_strobe - s0), 32'd0);
        slave_lat = 0;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h0); push(1'b1, 1'b0, 32'h500, 1'b0);
        t0 = cyc;
        @(posedge clk); #1; release_m(1'b1);
        wait_done("t6_after");
        chk("t6_latency", 32'(cyc - t0), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
